// File: rtl/cla_pkg.sv
// Shared types and constants for the word-serial carry-lookahead adder.
package cla_pkg;

  localparam int SLICE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice index width: at least one bit even for a single-slice build.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla8_slice.sv
// Combinational SLICE_W-bit carry-lookahead adder built from generate/propagate terms.
import cla_pkg::*;

module cla8_slice #(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;
  logic               pp;
  logic               gg;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum-of-products of g/p terms and cin, not a chain of c[i].
  always_comb begin
    c    = '0;
    pp   = 1'b1;
    gg   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      pp = 1'b1;
      gg = 1'b0;
      for (int j = i; j >= 0; j--) begin
        gg = gg | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = gg | (pp & cin);
    end
  end

  assign s  = p ^ c[SLICE_W-1:0];
  assign co = c[SLICE_W];

endmodule

// File: rtl/cla_word_sequencer.sv
// Word-serial adder: W-bit operands added one slice per cycle, LSB first, through one CLA slice.
import cla_pkg::*;

module cla_word_sequencer #(
  parameter  int SLICE_W    = SLICE_W_DEF,
  parameter  int NUM_SLICES = 4,
  localparam int W          = SLICE_W * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [W:0]   result,
  output logic         busy
);

  localparam int                 IDX_W    = idx_w(NUM_SLICES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ov_q, ov_d;

  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;

  cla8_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a   (a_q[int'(idx_q)*SLICE_W +: SLICE_W]),
    .b   (b_q[int'(idx_q)*SLICE_W +: SLICE_W]),
    .cin (carry_q),
    .s   (sl_s),
    .co  (sl_co)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign result    = {cout_q, sum_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[int'(idx_q)*SLICE_W +: SLICE_W] = sl_s;
        carry_d = sl_co;
        // Top slice: publish the accumulator including the slice just computed.
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_d;
          cout_d  = sl_co;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
    end
  end

endmodule
